// File: rtl/usb_kbd_scheduler.sv
// usb_kbd_scheduler
//   Keyboard event scheduler between the USB HID host and the 6502 bus.
//   Detects new key presses in HID reports, generates typematic auto-repeat
//   (initial delay, then fixed rate), and queues ASCII characters together
//   with their modifier byte in a small FIFO read through a register window.
//   The scancode->ASCII table is external: scan_o/mods_o go out and char_i
//   is sampled in the same cycle.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   report_i, typ_i       one-cycle "new report" strobe, device type (1 = keyboard)
//   key1_i, key2_i        scancode slots of the current report
//   mods_i                modifier byte of the current report
//   scan_o, mods_o        scancode/modifiers presented to the external lookup
//   char_i                ASCII from the lookup, 0 = unmapped
//   cs_i, R_W_n           register access strobe, 1 = read / 0 = write
//   reg_addr_i, data_i    register address, write data
//   data_o                combinational read data
//
// Registers
//   00 R  {6'd0, ovf, !empty}    reading clears ovf
//   01 R  head character         reading pops
//   02 R  head modifiers         no pop
//   03 RW {6'd0, flush, rep_en}  flush acts on the write itself and reads 0
module usb_kbd_scheduler #(
    parameter int DEPTH    = 8,
    parameter int CLK_DIV  = 27000,
    parameter int DELAY_MS = 500,
    parameter int RATE_MS  = 33
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       report_i,
    input  logic [1:0] typ_i,
    input  logic [7:0] key1_i,
    input  logic [7:0] key2_i,
    input  logic [7:0] mods_i,
    output logic [7:0] scan_o,
    output logic [7:0] mods_o,
    input  logic [7:0] char_i,
    input  logic       cs_i,
    input  logic       R_W_n,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CMAX = (DELAY_MS > RATE_MS) ? DELAY_MS : RATE_MS;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

    state_t         state, state_nx;
    logic [PW-1:0]  presc;
    logic           tick;
    logic [CW-1:0]  ctr;
    logic [7:0]     prev0, prev1, rep_key, rep_mods, press_key;
    logic           kbd, other, new1, new2, press, rel, expire;
    logic           push, push_ok, pop, flush, wr_ctrl, st_read, full, ovf_set;
    logic           ovf, rep_en;
    logic [7:0]     mem_char [DEPTH];
    logic [7:0]     mem_mods [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [AW:0]    count;
    logic           unused_bits;

    assign unused_bits = ^data_i[7:2];

    // Report decoding and press detection (slot 1 has priority over slot 2)
    assign kbd       = report_i && (typ_i == 2'd1);
    assign other     = report_i && (typ_i != 2'd1);
    assign new1      = (key1_i != 8'h00) && (key1_i != prev0) && (key1_i != prev1);
    assign new2      = (key2_i != 8'h00) && (key2_i != prev0) && (key2_i != prev1);
    assign press     = kbd && (new1 || new2);
    assign press_key = new1 ? key1_i : key2_i;
    assign rel       = kbd && !press && (rep_key != key1_i) && (rep_key != key2_i);

    // 1 ms prescaler, free-running from reset
    assign tick = (presc == PW'(CLK_DIV - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM: next state. Report-driven transitions outrank timer expiry, so an
    // expire coinciding with a press, release or foreign report is discarded.
    always_comb begin
        state_nx = state;
        expire   = 1'b0;
        if (other)                  state_nx = IDLE;
        else if (press)             state_nx = DELAY;
        else if (rel)               state_nx = IDLE;
        else if (state != IDLE) begin
            if (!rep_en)            state_nx = IDLE;
            else if (tick && ctr == CW'(1)) begin
                expire   = 1'b1;
                state_nx = REPEAT;
            end
        end
    end

    // FSM: outputs. A press drives the lookup with the new key in the same
    // cycle; otherwise the lookup always sees the held repeat key.
    always_comb begin
        scan_o = rep_key;
        mods_o = rep_mods;
        if (press) begin
            scan_o = press_key;
            mods_o = mods_i;
        end
        push = (press || expire) && (char_i != 8'h00) && !flush;
    end

    // Key history, repeat key and delay/rate counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev0    <= '0;
            prev1    <= '0;
            rep_key  <= '0;
            rep_mods <= '0;
            ctr      <= '0;
        end else begin
            if (other) begin
                prev0 <= '0;
                prev1 <= '0;
            end else if (kbd) begin
                prev0 <= key1_i;
                prev1 <= key2_i;
            end
            if (press) begin
                rep_key  <= press_key;
                rep_mods <= mods_i;
                ctr      <= CW'(DELAY_MS);
            end else if (expire) begin
                ctr <= CW'(RATE_MS);
            end else if (state != IDLE && tick) begin
                ctr <= ctr - 1'b1;
            end
        end
    end

    // Register access decode
    assign wr_ctrl = cs_i && !R_W_n && (reg_addr_i == 8'h03);
    assign flush   = wr_ctrl && data_i[1];
    assign st_read = cs_i && R_W_n && (reg_addr_i == 8'h00);
    assign pop     = cs_i && R_W_n && (reg_addr_i == 8'h01) && (count != '0) && !flush;
    assign full    = (count == (AW+1)'(DEPTH));
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    // FIFO storage needs no reset: pointers and count define validity
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_char[wp] <= char_i;
            mem_mods[wp] <= mods_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end

    // Sticky overflow wins over a simultaneous status read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf    <= 1'b0;
            rep_en <= 1'b1;
        end else begin
            if (wr_ctrl)      rep_en <= data_i[0];
            if (ovf_set)      ovf <= 1'b1;
            else if (st_read) ovf <= 1'b0;
        end
    end

    always_comb begin
        data_o = '0;
        case (reg_addr_i)
            8'h00:   data_o = {6'd0, ovf, (count != '0)};
            8'h01:   if (count != '0) data_o = mem_char[rp];
            8'h02:   if (count != '0) data_o = mem_mods[rp];
            8'h03:   data_o = {7'd0, rep_en};
            default: data_o = '0;
        endcase
    end

endmodule
